// File: rtl/matrix_scan_driver.sv
// Column-multiplexed driver for the 5x7 attack-round LED matrix; snapshots the map once per frame.
// Define SCAN_BLANKING_EN to insert dark BLANK_CYCLES gaps between columns (anti-ghosting).
module matrix_scan_driver #(
  parameter int unsigned DATA_WIDTH    = 35,
  parameter int unsigned COLUNE_SIZE   = 7,
  parameter int unsigned TOTAL_COLUNES = 5,
  parameter int unsigned DWELL_CYCLES  = 50000,
  parameter int unsigned DWELL_WIDTH   = 16,
  parameter int unsigned BLANK_CYCLES  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_WIDTH-1:0]    matriz_data,
  output logic [TOTAL_COLUNES-1:0] colune_select,
  output logic [COLUNE_SIZE-1:0]   row_data,
  output logic                     frame_done
);

  localparam int unsigned IdxW = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(TOTAL_COLUNES - 1);
  localparam logic [DWELL_WIDTH-1:0] DwellLast = DWELL_WIDTH'(DWELL_CYCLES - 1);

  if (DATA_WIDTH != COLUNE_SIZE * TOTAL_COLUNES || DWELL_CYCLES == 0 || BLANK_CYCLES == 0)
  begin : g_param_check
    $error("matrix_scan_driver: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StScan
`ifdef SCAN_BLANKING_EN
    , StBlank
`endif
  } state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [IdxW-1:0]         idx_inc;
  logic [DWELL_WIDTH-1:0]  dwell_q;
  logic [DATA_WIDTH-1:0]   snap_q;

  assign idx_inc = idx_q + 1'b1;

  // Column 0 is the most significant slice of the map word.
  function automatic logic [COLUNE_SIZE-1:0] col_bits(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [IdxW-1:0]       c);
    logic [DATA_WIDTH-1:0] sh;
    sh = d >> ((TOTAL_COLUNES - 1 - 32'(c)) * COLUNE_SIZE);
    return sh[COLUNE_SIZE-1:0];
  endfunction

  function automatic logic [TOTAL_COLUNES-1:0] strobe(input logic [IdxW-1:0] c);
    logic [TOTAL_COLUNES-1:0] s;
    s    = '1;
    s[c] = 1'b0;
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      dwell_q       <= '0;
      snap_q        <= '1;
      colune_select <= '1;
      row_data      <= '1;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state_q       <= StIdle;
        idx_q         <= '0;
        dwell_q       <= '0;
        colune_select <= '1;
        row_data      <= '1;
      end else begin
        case (state_q)
          StIdle: begin
            state_q       <= StLoad;
            colune_select <= '1;
            row_data      <= '1;
          end
          StLoad: begin
            // Outputs are registered, so column 0 is driven from the word being captured.
            snap_q        <= matriz_data;
            idx_q         <= '0;
            dwell_q       <= '0;
            state_q       <= StScan;
            colune_select <= strobe('0);
            row_data      <= col_bits(matriz_data, '0);
          end
          StScan: begin
            if (dwell_q == DwellLast) begin
              dwell_q <= '0;
              if (idx_q == IdxLast) begin
                idx_q         <= '0;
                state_q       <= StLoad;
                frame_done    <= 1'b1;
                colune_select <= '1;
                row_data      <= '1;
              end else begin
                idx_q <= idx_inc;
`ifdef SCAN_BLANKING_EN
                state_q       <= StBlank;
                colune_select <= '1;
                row_data      <= '1;
`else
                colune_select <= strobe(idx_inc);
                row_data      <= col_bits(snap_q, idx_inc);
`endif
              end
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
`ifdef SCAN_BLANKING_EN
          StBlank: begin
            // Dwell counter doubles as the blank-gap counter.
            if (dwell_q == DWELL_WIDTH'(BLANK_CYCLES - 1)) begin
              dwell_q       <= '0;
              state_q       <= StScan;
              colune_select <= strobe(idx_q);
              row_data      <= col_bits(snap_q, idx_q);
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
`endif
          default: begin
            state_q       <= StIdle;
            colune_select <= '1;
            row_data      <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver: frame-position reference model feeding a scoreboard.
module tb_matrix_scan_driver;

  localparam int T  = 5;
  localparam int R  = 7;
  localparam int DW = 35;
  localparam int D  = 4;
`ifdef SCAN_BLANKING_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif
  localparam int L = T * D + (T - 1) * B + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] data;
  logic [T-1:0]  colune_select;
  logic [R-1:0]  row_data;
  logic          frame_done;

  matrix_scan_driver #(
    .DATA_WIDTH   (DW),
    .COLUNE_SIZE  (R),
    .TOTAL_COLUNES(T),
    .DWELL_CYCLES (D),
    .DWELL_WIDTH  (16),
    .BLANK_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable       (enable),
    .matriz_data  (data),
    .colune_select(colune_select),
    .row_data     (row_data),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [T-1:0] col;
    logic [R-1:0] row;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Model: position within the frame, 0 = LOAD (dark) cycle.
  bit            m_active;
  int            m_pos;
  logic [DW-1:0] m_snap;
  bit            m_fd;
  int            m_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int lit_col(input int pos);
    int q;
    if (pos == 0) return -1;
    q = pos - 1;
    if ((q % (D + B)) >= D) return -1;
    return q / (D + B);
  endfunction

  function automatic exp_t expect_out();
    exp_t e;
    int   c;
    e.col = '1;
    e.row = '1;
    e.fd  = m_fd;
    if (m_active) begin
      c = lit_col(m_pos);
      if (c >= 0) begin
        e.col = ~(T'(1) << c);
        e.row = R'(m_snap >> ((T - 1 - c) * R));
      end
    end
    return e;
  endfunction

  // Advance the model for the coming edge, push its prediction, then compare after the edge.
  task automatic step();
    exp_t e;
    if (!rst_n) begin
      m_active = 0;
      m_fd     = 0;
      m_snap   = '1;
    end else if (!enable) begin
      m_active = 0;
      m_fd     = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_pos    = 0;
      m_fd     = 0;
    end else if (m_pos == 0) begin
      m_snap = data;
      m_pos  = 1;
      m_fd   = 0;
    end else if (m_pos == L - 1) begin
      m_pos = 0;
      m_fd  = 1;
      m_frames++;
    end else begin
      m_pos++;
      m_fd = 0;
    end
    exp_q.push_back(expect_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("colune_select", 32'(colune_select), 32'(e.col));
    check("row_data", 32'(row_data), 32'(e.row));
    check("frame_done", 32'(frame_done), 32'(e.fd));
  endtask

  function automatic bit at_col(input int c);
    return m_active && lit_col(m_pos) == c;
  endfunction

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    data     = '0;
    m_active = 0;
    m_pos    = 0;
    m_snap   = '1;
    m_fd     = 0;
    m_frames = 0;

    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();

    // Column mapping, then wipe the map while column 2 of the second frame is lit.
    data   = 35'h7_F0FF_00AA;
    enable = 1'b1;
    for (int i = 0; i < 3 * L + 4; i++) begin
      if (m_frames == 1 && at_col(2)) data = '0;
      step();
    end

    // Random map, then abort during column 3.
    data = DW'({$urandom(), $urandom()});
    repeat (L + 2) step();
    for (int i = 0; i < 2 * L && !at_col(3); i++) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (L + 3) step();

    // Asynchronous reset between edges while a column is lit.
    for (int i = 0; i < 2 * L && !at_col(1); i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_col", 32'(colune_select), 32'h1f);
    check("async_row", 32'(row_data), 32'h7f);
    check("async_fd", 32'(frame_done), 32'h0);
    m_active = 0;
    m_fd     = 0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (L + 3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
